serial_link_phy_tx_serdes: RTL

- Parametrised successor to the serial-link PHY TX channel, generalised to NumChannels source-synchronous channels sharing one clock divider and phase shifter.
- Serialisation ratio is generic: 1 = SDR, 2 = DDR, 4 and 8 = multi-period DDR frames.
- Adds an explicit IDLE/RUN state machine with a true valid/ready handshake, gap-free back-to-back frames, and config latching at frame start.
- Adds per-channel enable with a parked clock.
- Sits between the data-link layer and the pads.

---
 rtl/serial_link_phy_tx_serdes.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/serial_link_phy_tx_serdes.sv
// Multi-channel source-synchronous TX serialiser: a shared period counter and
// phase shifter drive per-channel forwarded clocks and lane data, one frame per handshake.
//
// state | meaning
// IDLE  | outputs parked at 0, ready follows live config legality
// RUN   | frame in flight, ready only in the frame's last cycle
module serial_link_phy_tx_serdes #(
    parameter int NumChannels = 1,
    parameter int NumLanes    = 8,
    parameter int SerRatio    = 2,
    parameter int MaxClkDiv   = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [$clog2(MaxClkDiv):0]            clk_div_i,
    input  logic [$clog2(MaxClkDiv):0]            clk_shift_start_i,
    input  logic [$clog2(MaxClkDiv):0]            clk_shift_end_i,
    input  logic [NumChannels-1:0]                channel_en_i,
    input  logic [NumChannels*NumLanes*SerRatio-1:0] data_out_i,
    input  logic                                  data_out_valid_i,
    output logic                                  data_out_ready_o,
    output logic [NumChannels-1:0]                rcv_clk_o,
    output logic [NumChannels*NumLanes-1:0]       data_o
);
    localparam int CW = $clog2(MaxClkDiv) + 1;
    localparam int FW = NumLanes * SerRatio;
    localparam int NP = (SerRatio == 1) ? 1 : SerRatio / 2;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]                      state_q, state_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [1:0]                      per_q, per_d;
    logic [CW-1:0]                   div_q, div_d;
    logic [CW-1:0]                   start_q, start_d;
    logic [CW-1:0]                   end_q, end_d;
    logic [NumChannels*FW-1:0]       word_q, word_d;
    logic                            ph_q, ph_d;
    logic [NumChannels-1:0]          rcv_clk_q, rcv_clk_d;
    logic [NumChannels*NumLanes-1:0] data_q, data_d;

    logic       cfg_legal;
    logic       wrap;
    logic       last_per;
    logic       frame_last;
    logic       xfer;
    logic [2:0] slot;

    assign cfg_legal = (clk_div_i >= CW'(2))
                     && ((SerRatio == 1) || !clk_div_i[0])
                     && (clk_shift_start_i < clk_shift_end_i)
                     && (clk_shift_end_i < clk_div_i);

    assign wrap       = (cnt_q == div_q - CW'(1));
    assign last_per   = (per_q == 2'(NP - 1));
    assign frame_last = (state_q == RUN) && wrap && last_per;

    assign data_out_ready_o = !rst_i && cfg_legal && ((state_q == IDLE) || frame_last);
    assign xfer             = data_out_valid_i && data_out_ready_o;

    always_comb begin
        slot = 3'd0;
        if (SerRatio != 1) begin
            slot = {per_q, (cnt_q >= (div_q >> 1))};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        per_d     = per_q;
        div_d     = div_q;
        start_d   = start_q;
        end_d     = end_q;
        word_d    = word_q;
        ph_d      = ph_q;
        rcv_clk_d = '0;
        data_d    = '0;
        case (state_q)
            IDLE: begin
                ph_d = 1'b0;
                if (xfer) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    per_d   = '0;
                end
            end
            default: begin
                cnt_d = wrap ? '0 : cnt_q + CW'(1);
                if (wrap) begin
                    per_d = last_per ? 2'd0 : per_q + 2'd1;
                end
                if (cnt_q == start_q) begin
                    ph_d = 1'b1;
                end else if (cnt_q == end_q) begin
                    ph_d = 1'b0;
                end
                rcv_clk_d = {NumChannels{ph_d}} & channel_en_i;
                for (int c = 0; c < NumChannels; c++) begin
                    data_d[c*NumLanes +: NumLanes] = channel_en_i[c]
                        ? word_q[c*FW + int'(slot)*NumLanes +: NumLanes] : '0;
                end
                if (frame_last && !xfer) begin
                    state_d = IDLE;
                end
            end
        endcase
        // Config and word are captured only at a frame start, from IDLE or back-to-back.
        if (xfer) begin
            div_d   = clk_div_i;
            start_d = clk_shift_start_i;
            end_d   = clk_shift_end_i;
            word_d  = data_out_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            per_q     <= '0;
            div_q     <= '0;
            start_q   <= '0;
            end_q     <= '0;
            word_q    <= '0;
            ph_q      <= 1'b0;
            rcv_clk_q <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            div_q     <= div_d;
            start_q   <= start_d;
            end_q     <= end_d;
            word_q    <= word_d;
            ph_q      <= ph_d;
            rcv_clk_q <= rcv_clk_d;
            data_q    <= data_d;
        end
    end

    assign rcv_clk_o = rcv_clk_q;
    assign data_o    = data_q;

    a_params: assert property (@(posedge clk_i)
        ((SerRatio == 1) || (SerRatio == 2) || (SerRatio == 4) || (SerRatio == 8)) && (NumLanes >= 1));

    a_cfg_legal: assert property (@(posedge clk_i) disable iff (rst_i)
        ((state_q == IDLE) && data_out_valid_i) |-> cfg_legal);

endmodule
